// File: rtl/common_pkg.sv
// Shared definitions for the tree switch datapath.
// Holds the default VC geometry and the credit helpers. FIFOs and credit
// arbiters both use these helpers, so they agree on the initial credit value
// and on the credit counter width.
package common_pkg;

    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;

    // Width of a counter that holds 0 .. depth-1 credits.
    function automatic int credit_cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // A downstream FIFO of this depth advertises depth-1 credits after reset.
    function automatic int CREDIT_INIT(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// NREQ-wide round-robin arbiter.
// The search starts one past the last granted index and wraps. The pointer
// moves to the granted index only when en is high and a grant was issued.
// After reset the pointer sits at NREQ-1, so index 0 is searched first.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active-high
//   req  - NREQ request vector (already qualified by the caller)
//   en   - allows the pointer to follow this cycle's grant
//   gnt  - one-hot/zero grant, combinational from req and the pointer
module rr_arb #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0] ptr;
    logic             found;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path through the loop can leave a latch behind.
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            automatic int idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDX_W'(NREQ - 1);
        end else if (en && (|gnt)) begin
            for (int j = 0; j < NREQ; j++) begin
                if (gnt[j]) ptr <= IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/t_port_credit_arb.sv
// Per-output-port credit tracker and arbiter for the tree switch.
// One instance serves each output direction. It keeps a downstream credit
// counter per VC and picks one of the 2*VC_W input VC FIFO heads routed here.
// A requester competes only while its VC has a credit. The grant, mux select
// and output valid are combinational. Only the credit counters are state,
// plus the round-robin pointer when FAIR_VC_ARB=1.
//
// Ports:
//   clk        - clock
//   rst        - asynchronous reset, active-high; counters refill at once
//   req        - requester j has a head flit for this port (j < VC_W: lower
//                direction, j >= VC_W: upper direction; VC = j mod VC_W)
//   credit_gnt - downstream returned one credit for VC v this cycle
//   gnt        - one-hot/zero pop grant to requester j
//   sel        - output mux select = granted index, 0 when idle
//   o_v        - one-hot/zero per-VC output valid
//   cred       - per-VC credit counts, VC0 in the LSBs
module t_port_credit_arb
    import common_pkg::*;
#(
    parameter int VC_W          = DEFAULT_VC_W,
    parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
    parameter int FAIR_VC_ARB   = 0,
    parameter int NREQ          = VC_W * 2,
    parameter int SEL_W         = $clog2(VC_W * 2),
    parameter int CRED_W        = credit_cnt_w(VC_FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [VC_W-1:0]        credit_gnt,
    output logic [NREQ-1:0]        gnt,
    output logic [SEL_W-1:0]       sel,
    output logic [VC_W-1:0]        o_v,
    output logic [VC_W*CRED_W-1:0] cred
);

    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDIT_INIT(VC_FIFO_DEPTH));

    logic [VC_W-1:0] has_cred;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] arb_gnt;

    // Gating on a non-zero credit keeps counters from going below zero.
    // rst blocks every grant while it is held.
    always_comb begin
        elig = '0;
        for (int j = 0; j < NREQ; j++) begin
            elig[j] = req[j] & has_cred[j % VC_W] & ~rst;
        end
    end

    generate
        if (FAIR_VC_ARB != 0) begin : g_rr
            rr_arb #(
                .NREQ(NREQ)
            ) u_rr_arb (
                .clk(clk),
                .rst(rst),
                .req(elig),
                .en (1'b1),
                .gnt(arb_gnt)
            );
        end else begin : g_fixed
            // Two's-complement trick: isolates the lowest set bit.
            assign arb_gnt = elig & (~elig + NREQ'(1));
        end
    endgenerate

    assign gnt = arb_gnt;

    always_comb begin
        sel = '0;
        o_v = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (arb_gnt[j]) begin
                sel            = SEL_W'(j);
                o_v[j % VC_W]  = 1'b1;
            end
        end
    end

    // One counter per VC. A send and a returned credit in the same cycle
    // cancel out. A return while already full saturates the counter; that
    // case breaks the credit protocol.
    for (genvar v = 0; v < VC_W; v++) begin : g_vc
        logic [CRED_W-1:0] cnt;

        assign has_cred[v]               = (cnt != '0);
        assign cred[v*CRED_W +: CRED_W]  = cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= CRED_FULL;
            end else begin
                case ({o_v[v], credit_gnt[v]})
                    2'b10: cnt <= cnt - CRED_W'(1);
                    2'b01: begin
                        assert (cnt != CRED_FULL)
                            else $warning("credit returned on full VC %0d", v);
                        if (cnt != CRED_FULL) cnt <= cnt + CRED_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_t_port_credit_arb.sv
// Bench for t_port_credit_arb with VC_W=2, VC_FIFO_DEPTH=4 (3 credits/VC).
// Two instances share req: dut_fp (fixed priority) and dut_rr (round-robin).
// The reference model keeps integer credit counts and the last-granted index.
// It picks the winner by scanning requesters in priority order.
module tb_t_port_credit_arb;

    localparam int VC_W  = 2;
    localparam int DEPTH = 4;
    localparam int NREQ  = 4;
    localparam int CMAX  = DEPTH - 1;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] cg_fp, cg_rr;
    logic [3:0] gnt_fp, gnt_rr;
    logic [1:0] sel_fp, sel_rr;
    logic [1:0] ov_fp, ov_rr;
    logic [3:0] cred_fp, cred_rr;

    int checks   = 0;
    int failures = 0;

    // Reference model state: index 0 = fixed-priority DUT, 1 = round-robin DUT.
    int m_cred [2][VC_W];
    int m_ptr;

    t_port_credit_arb #(.VC_W(VC_W), .VC_FIFO_DEPTH(DEPTH), .FAIR_VC_ARB(0)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .credit_gnt(cg_fp),
        .gnt(gnt_fp), .sel(sel_fp), .o_v(ov_fp), .cred(cred_fp)
    );

    t_port_credit_arb #(.VC_W(VC_W), .VC_FIFO_DEPTH(DEPTH), .FAIR_VC_ARB(1)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .credit_gnt(cg_rr),
        .gnt(gnt_rr), .sel(sel_rr), .o_v(ov_rr), .cred(cred_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int exp_idx(input int d);
        for (int k = 0; k < NREQ; k++) begin
            automatic int j = (d == 1) ? (m_ptr + 1 + k) % NREQ : k;
            if (req[j] && m_cred[d][j % VC_W] > 0) return j;
        end
        return -1;
    endfunction

    function automatic logic [1:0] exp_ov(input int d);
        automatic int i = exp_idx(d);
        return (i < 0) ? 2'b00 : 2'(1 << (i % VC_W));
    endfunction

    // {gnt, sel, o_v, cred} as the model predicts it for the current inputs.
    function automatic logic [11:0] exp_all(input int d);
        automatic int i = exp_idx(d);
        logic [3:0] g;
        logic [1:0] s;
        g = (i < 0) ? 4'b0000 : 4'(1 << i);
        s = (i < 0) ? 2'd0 : 2'(i);
        return {g, s, exp_ov(d), 2'(m_cred[d][1]), 2'(m_cred[d][0])};
    endfunction

    task automatic model_init();
        for (int d = 0; d < 2; d++)
            for (int v = 0; v < VC_W; v++) m_cred[d][v] = CMAX;
        m_ptr = NREQ - 1;
    endtask

    // Advance the model by one clock edge, then move to the next drive point.
    task automatic cycle();
        for (int d = 0; d < 2; d++) begin
            automatic int i = exp_idx(d);
            automatic logic [1:0] cg = (d == 1) ? cg_rr : cg_fp;
            for (int v = 0; v < VC_W; v++) begin
                automatic bit send = (i >= 0) && (i % VC_W == v);
                if (send && !cg[v]) m_cred[d][v]--;
                else if (!send && cg[v] && m_cred[d][v] < CMAX) m_cred[d][v]++;
            end
            if (d == 1 && i >= 0) m_ptr = i;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        cg_fp = '0;
        cg_rr = '0;
        @(negedge clk);
        rst = 1'b0;
        model_init();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b1;
        req   = 4'b1111;
        cg_fp = '0;
        cg_rr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({gnt_fp, sel_fp, ov_fp, cred_fp} !== 12'b0000_00_00_1111) begin
            failures++;
            $display("FAIL reset_fp got=%b want=%b", {gnt_fp, sel_fp, ov_fp, cred_fp}, 12'b0000_00_00_1111);
        end
        checks++;
        if ({gnt_rr, sel_rr, ov_rr, cred_rr} !== 12'b0000_00_00_1111) begin
            failures++;
            $display("FAIL reset_rr got=%b want=%b", {gnt_rr, sel_rr, ov_rr, cred_rr}, 12'b0000_00_00_1111);
        end
        do_reset();
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            req = 4'b0001; cg_fp = '0; cg_rr = '0;
            #1;
            checks++;
            if (gnt_fp !== ((c < 3) ? 4'b0001 : 4'b0000) || ov_fp !== ((c < 3) ? 2'b01 : 2'b00) || sel_fp !== 2'd0) begin
                failures++;
                $display("FAIL exhaust_fp c=%0d got gnt=%b ov=%b sel=%0d", c, gnt_fp, ov_fp, sel_fp);
            end
            checks++;
            if ({gnt_rr, sel_rr, ov_rr, cred_rr} !== exp_all(1)) begin
                failures++;
                $display("FAIL exhaust_rr c=%0d got=%b want=%b", c, {gnt_rr, sel_rr, ov_rr, cred_rr}, exp_all(1));
            end
            cycle();
        end
        checks++;
        if (cred_fp[1:0] !== 2'd0) begin
            failures++;
            $display("FAIL exhaust_cred0 got=%0d want=0", cred_fp[1:0]);
        end
        // A returned credit is not visible until the next cycle.
        cg_fp = 2'b01; cg_rr = 2'b01;
        #1;
        checks++;
        if (gnt_fp !== 4'b0000 || gnt_rr !== 4'b0000) begin
            failures++;
            $display("FAIL no_bypass got fp=%b rr=%b want=0000", gnt_fp, gnt_rr);
        end
        cycle();
        cg_fp = '0; cg_rr = '0;
        #1;
        checks++;
        if (gnt_fp !== 4'b0001 || gnt_rr !== 4'b0001) begin
            failures++;
            $display("FAIL resume got fp=%b rr=%b want=0001", gnt_fp, gnt_rr);
        end
        cycle();
    endtask

    task automatic test_rotation();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req   = 4'b1111;
            cg_fp = exp_ov(0);
            cg_rr = exp_ov(1);
            #1;
            checks++;
            if (gnt_rr !== 4'(1 << (c % 4)) || sel_rr !== 2'(c % 4)) begin
                failures++;
                $display("FAIL rr_rotate c=%0d got gnt=%b sel=%0d want gnt=%b", c, gnt_rr, sel_rr, 4'(1 << (c % 4)));
            end
            checks++;
            if (gnt_fp !== 4'b0001) begin
                failures++;
                $display("FAIL fp_fixed c=%0d got=%b want=0001", c, gnt_fp);
            end
            cycle();
            checks++;
            if (cred_rr !== 4'hF || cred_fp !== 4'hF) begin
                failures++;
                $display("FAIL rotate_cred c=%0d got rr=%h fp=%h want=f", c, cred_rr, cred_fp);
            end
        end
    endtask

    task automatic test_vc0_starved();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req = 4'b0101; cg_fp = '0; cg_rr = '0;
            #1;
            checks++;
            if ({gnt_rr, sel_rr, ov_rr, cred_rr} !== exp_all(1) || {gnt_fp, sel_fp, ov_fp, cred_fp} !== exp_all(0)) begin
                failures++;
                $display("FAIL drain_vc0 c=%0d got rr=%b fp=%b want rr=%b fp=%b", c,
                         {gnt_rr, sel_rr, ov_rr, cred_rr}, {gnt_fp, sel_fp, ov_fp, cred_fp}, exp_all(1), exp_all(0));
            end
            cycle();
        end
        #1;
        checks++;
        if (gnt_fp !== 4'b0000 || gnt_rr !== 4'b0000 || ov_fp !== 2'b00) begin
            failures++;
            $display("FAIL vc0_starved got fp=%b rr=%b want 0000", gnt_fp, gnt_rr);
        end
    endtask

    task automatic test_simul_credit();
        do_reset();
        req = 4'b0010; cg_fp = '0; cg_rr = '0;
        cycle();
        cg_fp = 2'b10; cg_rr = 2'b10;
        #1;
        checks++;
        if (gnt_fp !== 4'b0010) begin
            failures++;
            $display("FAIL simul_send got=%b want=0010", gnt_fp);
        end
        cycle();
        checks++;
        if (cred_fp[3:2] !== 2'd2 || cred_rr[3:2] !== 2'd2) begin
            failures++;
            $display("FAIL simul_net got fp=%0d rr=%0d want=2", cred_fp[3:2], cred_rr[3:2]);
        end
        req = '0;
        cycle();
        // Protocol error: credit returned on a VC that is already full.
        cg_rr = 2'b00;
        cycle();
        checks++;
        if (cred_fp[3:2] !== 2'd3 || cred_fp !== {2'(m_cred[0][1]), 2'(m_cred[0][0])}) begin
            failures++;
            $display("FAIL overflow_sat got=%0d want=3", cred_fp[3:2]);
        end
        cg_fp = '0;
    endtask

    task automatic test_rr_skip();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req = 4'b0010; cg_fp = '0; cg_rr = '0;
            cycle();
        end
        checks++;
        if (cred_rr[3:2] !== 2'd0) begin
            failures++;
            $display("FAIL skip_drain got=%0d want=0", cred_rr[3:2]);
        end
        for (int c = 0; c < 4; c++) begin
            req   = 4'b0110;
            cg_fp = exp_ov(0);
            cg_rr = exp_ov(1);
            #1;
            checks++;
            if (gnt_rr !== 4'b0100 || gnt_fp !== 4'b0100) begin
                failures++;
                $display("FAIL skip_grant c=%0d got rr=%b fp=%b want=0100", c, gnt_rr, gnt_fp);
            end
            cycle();
        end
        // Pointer at 2: the search starts at 3 (no credit) and lands on 0.
        req   = 4'b1111;
        cg_fp = exp_ov(0);
        cg_rr = exp_ov(1);
        #1;
        checks++;
        if (gnt_rr !== 4'b0001) begin
            failures++;
            $display("FAIL skip_ptr got=%b want=0001", gnt_rr);
        end
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [1:0] cgv [2];
            req = 4'($urandom);
            for (int d = 0; d < 2; d++) begin
                automatic int i = exp_idx(d);
                for (int v = 0; v < VC_W; v++) begin
                    automatic bit send = (i >= 0) && (i % VC_W == v);
                    cgv[d][v] = ($urandom_range(0, 1) == 1) && (send || m_cred[d][v] < CMAX);
                end
            end
            cg_fp = cgv[0];
            cg_rr = cgv[1];
            #1;
            checks++;
            if ({gnt_fp, sel_fp, ov_fp, cred_fp} !== exp_all(0)) begin
                failures++;
                $display("FAIL random_fp n=%0d got=%b want=%b", n, {gnt_fp, sel_fp, ov_fp, cred_fp}, exp_all(0));
            end
            checks++;
            if ({gnt_rr, sel_rr, ov_rr, cred_rr} !== exp_all(1)) begin
                failures++;
                $display("FAIL random_rr n=%0d got=%b want=%b", n, {gnt_rr, sel_rr, ov_rr, cred_rr}, exp_all(1));
            end
            cycle();
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        req = 4'b0001;
        repeat (3) cycle();
        req = 4'b0010;
        repeat (2) cycle();
        checks++;
        if (cred_fp !== 4'b0100 || cred_rr !== 4'b0100) begin
            failures++;
            $display("FAIL midrun_pre got fp=%b rr=%b want=0100", cred_fp, cred_rr);
        end
        // Assert rst away from any clock edge: counters refill immediately.
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt_fp, sel_fp, ov_fp, cred_fp} !== 12'b0000_00_00_1111 || cred_rr !== 4'hF || gnt_rr !== 4'b0000) begin
            failures++;
            $display("FAIL midrun_rst got fp=%b rr_cred=%h rr_gnt=%b", {gnt_fp, sel_fp, ov_fp, cred_fp}, cred_rr, gnt_rr);
        end
        @(negedge clk);
        rst = 1'b0;
        model_init();
        #1;
        checks++;
        if ({gnt_rr, sel_rr, ov_rr, cred_rr} !== exp_all(1)) begin
            failures++;
            $display("FAIL midrun_after got=%b want=%b", {gnt_rr, sel_rr, ov_rr, cred_rr}, exp_all(1));
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        cg_fp = '0;
        cg_rr = '0;
        model_init();
        test_reset();
        test_credit_exhaust();
        test_rotation();
        test_vc0_starved();
        test_simul_credit();
        test_rr_skip();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net: the bench is a fixed sequence of cycles, so this never
    // triggers unless the simulation stalls.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/t_port_credit_arb.md
Name: t_port_credit_arb

Overview:
- Per-output-port controller for the tree switch datapath; one instance serves each output direction (l, r, u0).
- Tracks downstream credits per VC and arbitrates among the 2*VC_W input VC FIFOs whose head flits target this port.
- Drives the output mux select, per-VC output valid, and per-requester pop grant.
- Makes the output mux and credit flow-control self-contained, so routing logic only has to produce requests.

Parameters:
- VC_W, DEFAULT_VC_W: number of virtual channels.
- VC_FIFO_DEPTH, DEFAULT_VC_FIFO_DEPTH: downstream VC FIFO depth. Initial credits are VC_FIFO_DEPTH-1.
- FAIR_VC_ARB, 0: 0 = fixed priority (lowest requester index wins); 1 = round-robin.
- NREQ, VC_W*2: requester count. Derived; do not override.
- SEL_W, $clog2(VC_W*2): select width. Derived.
- CRED_W, $clog2(VC_FIFO_DEPTH): credit counter width. Derived.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  NREQ  requester j has a valid head flit routed to this port. j < VC_W is mux input j (lower-concatenated direction); j >= VC_W is the upper direction.
- credit_gnt  input  VC_W  downstream returned one credit for VC v this cycle.
- gnt  output  NREQ  one-hot/zero; pops requester j's FIFO this cycle.
- sel  output  SEL_W  mux select; equals the granted index, 0 when idle.
- o_v  output  VC_W  one-hot/zero output valid; bit (j mod VC_W) set on grant.
- cred  output  VC_W*CRED_W  current credit count per VC, VC0 in the LSBs (debug/verification).

Behaviour:
- Reset (async, immediate):
  - all credit counters = VC_FIFO_DEPTH-1;
  - rr pointer = NREQ-1, so index 0 is searched first;
  - gnt = 0, o_v = 0, sel = 0 while rst is high.
- Eligibility: requester j is eligible iff req[j] and cred[j mod VC_W] != 0.
- Arbitration is combinational, zero latency. gnt, sel and o_v settle in the same cycle as req. At most one grant per cycle.
- FAIR_VC_ARB=0: the lowest eligible index wins.
- FAIR_VC_ARB=1: search starts at ptr+1 and wraps modulo NREQ. At the clock edge after a grant, ptr <= granted index. With no grant, ptr holds.
- Credit update per VC v at each clock edge:
  - decrement if o_v[v];
  - increment if credit_gnt[v];
  - both in the same cycle: net unchanged.
- Credits never go below 0; eligibility gating guarantees this.
- credit_gnt[v] while cred[v] == VC_FIFO_DEPTH-1 (and no send on v) is a protocol error:
  - counter saturates at VC_FIFO_DEPTH-1;
  - a simulation assertion fires.
- A credit that returns in cycle t makes the VC eligible in cycle t+1 at the earliest; there is no combinational credit bypass.
- A requester whose VC has zero credits is skipped. In round-robin mode it does not block others, and the pointer does not move to it.
- rst asserted mid-transfer: counters are restored to full immediately. Upstream and downstream FIFOs are reset by the same rst.
- No other state exists. No output is registered except cred.

Decomposition:
- common_pkg gains credit_cnt_w(depth) and CREDIT_INIT(depth) = depth-1, so FIFOs and arbiters agree on the initial credit value.
- Sub-module: rr_arb (NREQ-wide round-robin arbiter with an enable-gated pointer update). It is instantiated when FAIR_VC_ARB=1; the fixed-priority path is inline.
- Credit counters stay in this module as a generate loop over VC_W.

Test Plan (VC_W=2, VC_FIFO_DEPTH=4 → 3 credits/VC, NREQ=4):
- Reset then idle → cred = {3,3}; gnt = 0, sel = 0, o_v = 0. Assert rst mid-run with cred = {0,1} → cred returns to {3,3} without waiting for a clock edge.
- req = 4'b0001 held 4 cycles, no credit return → gnt = 0001, o_v = 01, sel = 0 for 3 cycles; cycle 4 gnt = 0, cred[0] = 0. Pulse credit_gnt[0] → grant resumes on the following cycle.
- FAIR_VC_ARB=1, req = 4'b1111, credit_gnt = 2'b11 every cycle → grant sequence 0,1,2,3,0,… and cred stays {3,3}.
- FAIR_VC_ARB=0, same stimulus → gnt = 0001 every cycle. Then zero VC0's credits with req = 4'b0101 → no grant (both requesters are on VC0).
- Simultaneous send and credit_gnt on VC1 with cred[1] = 2 → cred[1] stays 2. credit_gnt[1] with cred[1] = 3 and no send → stays 3 and the assertion fires.
- FAIR_VC_ARB=1, req = 4'b0110, cred[1] = 0 → requester 2 is granted repeatedly, requester 1 is skipped, and ptr = 2.
